// File: rtl/div_unit.sv
// rtl/div_unit.sv - restoring shift-subtract divider, one quotient bit per clock
// DIV_SIGNED_EN: two's-complement operands, extra FIXUP state applies the result signs
module div_unit #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] rs1_reg,
   input  logic [N-1:0] rs2_reg,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] div_rd,
   output logic [N-1:0] div_rem,
   output logic         div_ex
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [N-1:0]  rem_q;
   logic [N-1:0]  quo_q;
   logic [N-1:0]  dvsr;
`ifdef DIV_SIGNED_EN
   logic          neg_q;
   logic          neg_r;
   logic          ovf;
`endif

   logic [N:0]    shifted;
   logic [N-1:0]  diff;
   logic          ge;
   logic [N-1:0]  rem_next;
   logic [N-1:0]  quo_next;

   // diff is only used when shifted >= dvsr, so the true result always fits in N bits
   assign shifted  = {rem_q, quo_q[N-1]};
   assign ge       = (shifted >= {1'b0, dvsr});
   assign diff     = shifted[N-1:0] - dvsr;
   assign rem_next = ge ? diff : shifted[N-1:0];
   assign quo_next = {quo_q[N-2:0], ge};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         count   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         div_rd  <= '0;
         div_rem <= '0;
         div_ex  <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  div_ex <= 1'b0;
                  if (rs2_reg == '0) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     div_rd  <= '1;
                     div_rem <= rs1_reg;
                     div_ex  <= 1'b1;
                  end else begin
                     state <= CALC;
                     count <= CW'(N);
                     rem_q <= '0;
`ifdef DIV_SIGNED_EN
                     quo_q <= rs1_reg[N-1] ? -rs1_reg : rs1_reg;
                     dvsr  <= rs2_reg[N-1] ? -rs2_reg : rs2_reg;
                     neg_q <= rs1_reg[N-1] ^ rs2_reg[N-1];
                     neg_r <= rs1_reg[N-1];
                     ovf   <= (rs1_reg == {1'b1, {(N-1){1'b0}}}) && (rs2_reg == '1);
`else
                     quo_q <= rs1_reg;
                     dvsr  <= rs2_reg;
`endif
                  end
               end
            end
            CALC: begin
               rem_q <= rem_next;
               quo_q <= quo_next;
               count <= count - CW'(1);
               if (count == CW'(1)) begin
`ifdef DIV_SIGNED_EN
                  state <= FIXUP;
`else
                  state   <= DONE;
                  done    <= 1'b1;
                  div_rd  <= quo_next;
                  div_rem <= rem_next;
`endif
               end
            end
`ifdef DIV_SIGNED_EN
            // most-negative / -1 yields magnitude 2^(N-1) with a positive sign, which is the required result
            FIXUP: begin
               state   <= DONE;
               done    <= 1'b1;
               div_rd  <= neg_q ? -quo_q : quo_q;
               div_rem <= neg_r ? -rem_q : rem_q;
               div_ex  <= ovf;
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit against a behavioural model
module tb_div_unit;

   localparam int N = 16;
`ifdef DIV_SIGNED_EN
   localparam int OP_LAT = N + 1;
`else
   localparam int OP_LAT = N;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] rs1 = '0;
   logic [N-1:0] rs2 = '0;
   logic         busy;
   logic         done;
   logic [N-1:0] div_rd;
   logic [N-1:0] div_rem;
   logic         div_ex;

   int checks = 0;
   int errors = 0;

   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic [N-1:0] m_rd = '0;
   logic [N-1:0] m_rem = '0;
   logic         m_ex = 1'b0;

   div_unit #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .rs1_reg (rs1),
      .rs2_reg (rs2),
      .busy    (busy),
      .done    (done),
      .div_rd  (div_rd),
      .div_rem (div_rem),
      .div_ex  (div_ex)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: results and number of edges after acceptance until done rises
   task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                          output logic [N-1:0] q, output logic [N-1:0] r,
                          output logic ex, output int lat);
      if (b == '0) begin
         q = '1; r = a; ex = 1'b1; lat = 0;
      end else begin
`ifdef DIV_SIGNED_EN
         int sa, sb;
         sa = $signed(a);
         sb = $signed(b);
         if (sa == -(1 << (N - 1)) && sb == -1) begin
            q = a; r = '0; ex = 1'b1;
         end else begin
            q = N'(sa / sb); r = N'(sa % sb); ex = 1'b0;
         end
`else
         q = a / b; r = a % b; ex = 1'b0;
`endif
         lat = OP_LAT;
      end
   endtask

   initial begin : model
      int left;
      logic [N-1:0] p_rd, p_rem;
      logic p_ex;
      left = 0; p_rd = '0; p_rem = '0; p_ex = 1'b0;
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_rd = '0; m_rem = '0; m_ex = 1'b0; left = 0;
         end else if (m_done) begin
            m_done = 1'b0; m_busy = 1'b0;
         end else if (m_busy) begin
            left--;
            if (left == 0) begin
               m_done = 1'b1; m_rd = p_rd; m_rem = p_rem; m_ex = p_ex;
            end
         end else if (start) begin
            ref_div(rs1, rs2, p_rd, p_rem, p_ex, left);
            m_busy = 1'b1;
            m_ex   = 1'b0;
            if (left == 0) begin
               m_done = 1'b1; m_rd = p_rd; m_rem = p_rem; m_ex = p_ex;
            end
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("div_rd", 32'(div_rd), 32'(m_rd));
         chk("div_rem", 32'(div_rem), 32'(m_rem));
         chk("div_ex", 32'(div_ex), 32'(m_ex));
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy === 1'b1) chk("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Issues one start pulse at a negedge, scrambles operands afterwards, returns edges until done rose
   task automatic op(input logic [N-1:0] a, input logic [N-1:0] b, output int edges);
      wait_idle();
      @(negedge clk);
      rs1 = a; rs2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rs1 = N'($urandom);
      rs2 = N'($urandom);
      edges = 0;
      while (done !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
   endtask

   task automatic op_expect(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] q, input logic [N-1:0] r, input logic ex);
      int edges;
      op(a, b, edges);
      chk({name, "_q"}, 32'(div_rd), 32'(q));
      chk({name, "_r"}, 32'(div_rem), 32'(r));
      chk({name, "_ex"}, 32'(div_ex), 32'(ex));
`ifndef DIV_SIGNED_EN
      if (!ex) begin
         chk({name, "_invariant"}, 32'((int'(div_rd) * int'(b) + int'(div_rem)) == int'(a)
                                       && div_rem < b), 32'd1);
      end
`endif
   endtask

   function automatic logic [N-1:0] pick();
      logic [N-1:0] corner [5];
      corner = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF};
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
      return N'($urandom);
   endfunction

   initial begin : stimulus
      int edges;
      @(negedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_rd", 32'(div_rd), 32'd0);
      chk("reset_rem", 32'(div_rem), 32'd0);
      chk("reset_ex", 32'(div_ex), 32'd0);
      rst = 1'b0;

      op(16'd100, 16'd7, edges);
      chk("basic_latency", 32'(edges), 32'(OP_LAT));
      chk("basic_q", 32'(div_rd), 32'd14);
      chk("basic_r", 32'(div_rem), 32'd2);
      chk("basic_ex", 32'(div_ex), 32'd0);
      chk("basic_busy_at_done", 32'(busy), 32'd1);

      op(16'd5, 16'd0, edges);
      chk("div0_done_first_cycle", 32'(edges), 32'd0);
      chk("div0_q", 32'(div_rd), 32'hFFFF);
      chk("div0_r", 32'(div_rem), 32'd5);
      chk("div0_ex", 32'(div_ex), 32'd1);
      op_expect("after_div0", 16'd9, 16'd4, 16'd2, 16'd1, 1'b0);

      op_expect("max_by_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0);
      op_expect("small_by_big", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0);
      op_expect("zero_dividend", 16'd0, 16'd9, 16'd0, 16'd0, 1'b0);
      op_expect("max_by_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0);
`ifdef DIV_SIGNED_EN
      op(16'hFFF9, 16'd2, edges);
      chk("neg7_by_2_latency", 32'(edges), 32'd17);
      chk("neg7_by_2_q", 32'(div_rd), 32'hFFFD);
      chk("neg7_by_2_r", 32'(div_rem), 32'hFFFF);
      op_expect("signed_ovf", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b1);
`endif

      // start held over several edges and pulsed again mid-calculation: one operation only
      wait_idle();
      @(negedge clk);
      rs1 = 16'd200; rs2 = 16'd9; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      while (done !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      chk("held_start_q", 32'(div_rd), 32'd22);
      chk("held_start_r", 32'(div_rem), 32'd2);

      // back-to-back: start raised during the done cycle is taken on the first IDLE edge
      rs1 = 16'd50; rs2 = 16'd6; start = 1'b1;
      @(negedge clk);
      chk("b2b_idle_gap", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_accept", 32'(busy), 32'd1);
      edges = 0;
      while (done !== 1'b1 && edges < 100) begin
         @(negedge clk);
         edges++;
      end
      chk("b2b_q", 32'(div_rd), 32'd8);
      chk("b2b_r", 32'(div_rem), 32'd2);

      // reset five cycles into an operation
      wait_idle();
      @(negedge clk);
      rs1 = 16'd1000; rs2 = 16'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_rd", 32'(div_rd), 32'd0);
      chk("midrst_rem", 32'(div_rem), 32'd0);
      chk("midrst_ex", 32'(div_ex), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      op_expect("after_rst", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

      // random traffic: model comparison runs every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         rs1 = pick();
         rs2 = ($urandom_range(0, 19) == 0) ? '0 : pick();
         rst = ($urandom_range(0, 599) == 0);
      end
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      repeat (30) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
